spi_shift_unit: RTL and testbench

SPI physical-layer front end for the Kalman filter chip: sits between the external microcontroller pins and the MCU controller FSM. It synchronizes SCK/MOSI/SS into the system clock domain and detects SCK edges. It deserializes MOSI into a 16-bit receive word and serializes the filter output onto MISO. It also produces the rising/falling-edge counter rollover flags that the controller sequences on, and accepts the controller's clear and load strobes.

---
 rtl/spi_shift_if.sv | 31 +++
 rtl/spi_shift_unit.sv | 142 ++++++++++++++
 tb/tb_spi_shift_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_if.sv
// SPI shift unit pin/controller bundle: raw SPI pins, controller strobes and
// the synchronized/deserialized results handed back to the controller.
interface spi_shift_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  sck_in;
   logic                  mosi_in;
   logic                  ss_in;
   logic                  r_clear_in;
   logic                  f_clear_in;
   logic                  load_data_in;
   logic [DATA_WIDTH-1:0] tx_data_in;
   logic                  mosi_sync_out;
   logic                  ss_sync_out;
   logic                  rollover_r_out;
   logic                  rollover_f_out;
   logic [DATA_WIDTH-1:0] rx_data_out;
   logic                  miso_out;

   // Shift unit side
   modport slave (
      input  sck_in, mosi_in, ss_in, r_clear_in, f_clear_in, load_data_in, tx_data_in,
      output mosi_sync_out, ss_sync_out, rollover_r_out, rollover_f_out, rx_data_out, miso_out
   );

   // Pin/controller side
   modport master (
      output sck_in, mosi_in, ss_in, r_clear_in, f_clear_in, load_data_in, tx_data_in,
      input  mosi_sync_out, ss_sync_out, rollover_r_out, rollover_f_out, rx_data_out, miso_out
   );
endinterface

// File: rtl/spi_shift_unit.sv
// SPI physical-layer front end: pin synchronizers, SCK edge detect, MOSI
// deserializer, MISO serializer and the word-rollover flags for the controller.
module spi_shift_unit #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   spi_shift_if.slave  bus
);

   localparam int unsigned W        = DATA_WIDTH;
   localparam int unsigned CW       = $clog2(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   // Synchronizer chains (sck has an extra stage for edge detection)
   logic sck_s1_q, sck_s2_q, sck_s3_q;
   logic mosi_s1_q, mosi_s2_q;
   logic ss_s1_q, ss_s2_q;

   // Receive side: only W-1 history bits are stored; the full word exists
   // combinationally as rx_word_c at the moment it completes.
   logic [W-2:0]  rx_shift_q, rx_shift_d;
   logic [W-1:0]  rx_word_c;
   logic [W-1:0]  rx_data_q, rx_data_d;
   logic [CW-1:0] r_count_q, r_count_d;
   logic          roll_r_q, roll_r_d;

   // Transmit side
   logic [W-1:0]  tx_shift_q, tx_shift_d;
   logic [CW-1:0] f_count_q, f_count_d;
   logic          roll_f_q, roll_f_d;
   logic          miso_q, miso_d;

   logic rise_c, fall_c;

   // Edge detect, gated by the synchronized slave select
   assign rise_c    =  sck_s2_q & ~sck_s3_q & ss_s2_q;
   assign fall_c    = ~sck_s2_q &  sck_s3_q & ss_s2_q;
   assign rx_word_c = {rx_shift_q, mosi_s2_q};

   // Next-state logic for receive and transmit datapaths
   always_comb begin
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      r_count_d  = r_count_q;
      roll_r_d   = roll_r_q;
      tx_shift_d = tx_shift_q;
      f_count_d  = f_count_q;
      roll_f_d   = roll_f_q;

      // Receive shifter moves on every detected rise, even when it is not counted
      if (rise_c) begin
         rx_shift_d = rx_word_c[W-2:0];
      end

      // Receive counter/flag: clear wins over a same-cycle rise
      if (bus.r_clear_in) begin
         r_count_d = '0;
         roll_r_d  = 1'b0;
      end else if (!ss_s2_q) begin
         r_count_d = '0;
      end else if (rise_c) begin
         if (r_count_q == CNT_LAST) begin
            r_count_d = '0;
            roll_r_d  = 1'b1;
            rx_data_d = rx_word_c;
         end else begin
            r_count_d = r_count_q + CW'(1);
         end
      end

      // Transmit shifter: a load overrides a same-cycle shift
      if (bus.load_data_in) begin
         tx_shift_d = bus.tx_data_in;
      end else if (fall_c) begin
         tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
      end

      // Transmit counter/flag: clear wins over a same-cycle fall
      if (bus.f_clear_in) begin
         f_count_d = '0;
         roll_f_d  = 1'b0;
      end else if (!ss_s2_q) begin
         f_count_d = '0;
      end else if (fall_c) begin
         if (f_count_q == CNT_LAST) begin
            f_count_d = '0;
            roll_f_d  = 1'b1;
         end else begin
            f_count_d = f_count_q + CW'(1);
         end
      end

      // MISO follows the shifter MSB the same cycle it changes; low when deselected
      miso_d = ss_s2_q ? tx_shift_d[W-1] : 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_s3_q   <= 1'b0;
         mosi_s1_q  <= 1'b0;
         mosi_s2_q  <= 1'b0;
         ss_s1_q    <= 1'b0;
         ss_s2_q    <= 1'b0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         r_count_q  <= '0;
         roll_r_q   <= 1'b0;
         tx_shift_q <= '0;
         f_count_q  <= '0;
         roll_f_q   <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         sck_s1_q   <= bus.sck_in;
         sck_s2_q   <= sck_s1_q;
         sck_s3_q   <= sck_s2_q;
         mosi_s1_q  <= bus.mosi_in;
         mosi_s2_q  <= mosi_s1_q;
         ss_s1_q    <= bus.ss_in;
         ss_s2_q    <= ss_s1_q;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         r_count_q  <= r_count_d;
         roll_r_q   <= roll_r_d;
         tx_shift_q <= tx_shift_d;
         f_count_q  <= f_count_d;
         roll_f_q   <= roll_f_d;
         miso_q     <= miso_d;
      end
   end

   assign bus.mosi_sync_out  = mosi_s2_q;
   assign bus.ss_sync_out    = ss_s2_q;
   assign bus.rollover_r_out = roll_r_q;
   assign bus.rollover_f_out = roll_f_q;
   assign bus.rx_data_out    = rx_data_q;
   assign bus.miso_out       = miso_q;

endmodule

// File: tb/tb_spi_shift_unit.sv
// Bench for spi_shift_unit: drives SPI frames at SCK = clk/8 and checks
// received words, MISO bits and flags against a frame-level reference model.
module tb_spi_shift_unit;

   localparam int unsigned W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_shift_if #(.DATA_WIDTH(W)) bus ();

   spi_shift_unit #(.DATA_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard queues
   logic [W-1:0] exp_rx_q[$];
   bit           exp_miso_q[$];

   // Reference model state (bit counts as plain integers)
   bit           m_ss, m_mosi, m_flag_r, m_flag_f;
   int           m_r_cnt, m_f_cnt;
   logic [W-1:0] m_bits, m_rx, m_tx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_bits = '0; m_rx = '0; m_tx = '0;
      m_r_cnt = 0; m_f_cnt = 0; m_flag_r = 1'b0; m_flag_f = 1'b0;
      exp_rx_q.delete();
      exp_miso_q.delete();
   endtask

   task automatic model_rise(input bit b, input bit clr);
      if (!m_ss) return;
      m_bits = {m_bits[W-2:0], b};
      if (clr) begin
         m_r_cnt  = 0;
         m_flag_r = 1'b0;
      end else begin
         m_r_cnt++;
         if (m_r_cnt == int'(W)) begin
            m_r_cnt = 0;
            m_rx    = m_bits;
            if (!m_flag_r) exp_rx_q.push_back(m_bits);
            m_flag_r = 1'b1;
         end
      end
   endtask

   task automatic model_fall();
      if (!m_ss) return;
      m_tx = m_tx << 1;
      m_f_cnt++;
      if (m_f_cnt == int'(W)) begin
         m_f_cnt  = 0;
         m_flag_f = 1'b1;
      end
   endtask

   // One SCK period: 4 clk low (data set up), 4 clk high
   task automatic send_bit(input bit b, input bit clr_at_rise);
      bus.mosi_in = b;
      m_mosi      = b;
      tick(4);
      exp_miso_q.push_back(m_ss ? m_tx[W-1] : 1'b0);
      model_rise(b, clr_at_rise);
      bus.sck_in = 1'b1;
      if (clr_at_rise) begin
         tick(2);
         bus.r_clear_in = 1'b1;
         tick(1);
         bus.r_clear_in = 1'b0;
         tick(1);
      end else begin
         tick(4);
      end
      bus.sck_in = 1'b0;
      model_fall();
   endtask

   task automatic send_bits(input logic [W-1:0] word, input int start, input int n, input bit clr_last);
      for (int i = 0; i < n; i++)
         send_bit(word[int'(W) - 1 - start - i], clr_last && (i == n - 1));
   endtask

   task automatic set_ss(input bit v);
      tick(4);
      bus.ss_in = v;
      m_ss      = v;
      if (!v) begin
         m_r_cnt = 0;
         m_f_cnt = 0;
      end
   endtask

   task automatic pulse_clear(input bit r, input bit f);
      bus.r_clear_in = r;
      bus.f_clear_in = f;
      tick(1);
      bus.r_clear_in = 1'b0;
      bus.f_clear_in = 1'b0;
      if (r) begin m_flag_r = 1'b0; m_r_cnt = 0; end
      if (f) begin m_flag_f = 1'b0; m_f_cnt = 0; end
   endtask

   task automatic load_tx(input logic [W-1:0] t);
      bus.tx_data_in   = t;
      bus.load_data_in = 1'b1;
      tick(1);
      bus.load_data_in = 1'b0;
      m_tx = t;
      @(negedge clk);
      chk("miso_after_load", 32'(bus.miso_out), 32'(m_ss ? t[W-1] : 1'b0));
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      chk({tag, ".rollover_r"}, 32'(bus.rollover_r_out), 32'(m_flag_r));
      chk({tag, ".rollover_f"}, 32'(bus.rollover_f_out), 32'(m_flag_f));
      chk({tag, ".rx_data"},    32'(bus.rx_data_out),    32'(m_rx));
      chk({tag, ".miso"},       32'(bus.miso_out),       32'(m_ss ? m_tx[W-1] : 1'b0));
      chk({tag, ".ss_sync"},    32'(bus.ss_sync_out),    32'(m_ss));
      chk({tag, ".mosi_sync"},  32'(bus.mosi_sync_out),  32'(m_mosi));
   endtask

   task automatic check_all_zero(input string tag);
      @(negedge clk);
      chk({tag, ".rollover_r"}, 32'(bus.rollover_r_out), 32'(0));
      chk({tag, ".rollover_f"}, 32'(bus.rollover_f_out), 32'(0));
      chk({tag, ".rx_data"},    32'(bus.rx_data_out),    32'(0));
      chk({tag, ".miso"},       32'(bus.miso_out),       32'(0));
      chk({tag, ".ss_sync"},    32'(bus.ss_sync_out),    32'(0));
      chk({tag, ".mosi_sync"},  32'(bus.mosi_sync_out),  32'(0));
   endtask

   // Monitor: each new receive rollover must match the oldest expected word
   bit prev_r = 1'b0;
   always @(negedge clk) begin
      if (bus.rollover_r_out === 1'b1 && !prev_r) begin
         if (exp_rx_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_word: unexpected rollover with rx_data_out %0h at %0t", bus.rx_data_out, $time);
         end else begin
            chk("rx_word", 32'(bus.rx_data_out), 32'(exp_rx_q.pop_front()));
         end
      end
      prev_r = (bus.rollover_r_out === 1'b1);
   end

   // Monitor: MISO must hold the expected bit when the master samples (SCK rise)
   always @(posedge bus.sck_in) begin
      if (exp_miso_q.size() != 0)
         chk("miso_bit", 32'(bus.miso_out), 32'(exp_miso_q.pop_front()));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] w;
      rst = 1'b1;
      bus.sck_in = 1'b0; bus.mosi_in = 1'b0; bus.ss_in = 1'b0;
      bus.r_clear_in = 1'b0; bus.f_clear_in = 1'b0; bus.load_data_in = 1'b0;
      bus.tx_data_in = '0;
      m_ss = 1'b0; m_mosi = 1'b0;
      model_reset();

      // Reset with random pin activity
      for (int i = 0; i < 2; i++) begin
         bus.sck_in = 1'($urandom); bus.mosi_in = 1'($urandom); bus.ss_in = 1'($urandom);
         bus.r_clear_in = 1'($urandom); bus.f_clear_in = 1'($urandom);
         bus.load_data_in = 1'($urandom); bus.tx_data_in = W'($urandom);
         tick(1);
      end
      check_all_zero("reset");
      rst = 1'b0;
      bus.sck_in = 1'b0; bus.mosi_in = 1'b0; bus.ss_in = 1'b0;
      bus.r_clear_in = 1'b0; bus.f_clear_in = 1'b0; bus.load_data_in = 1'b0;
      tick(6);
      check_all_zero("post_reset");

      // Receive 0xA5C3, flag sticky until cleared
      set_ss(1'b1);
      tick(4);
      send_bits(16'hA5C3, 0, 16, 1'b0);
      tick(6);
      check_state("rx_a5c3");
      chk("rx_a5c3.word", 32'(bus.rx_data_out), 32'h0000_A5C3);
      tick(10);
      check_state("rx_sticky");
      pulse_clear(1'b1, 1'b0);
      check_state("rx_clear");

      // Transmit 0x8001
      pulse_clear(1'b1, 1'b1);
      load_tx(16'h8001);
      send_bits(W'($urandom), 0, 16, 1'b0);
      tick(6);
      check_state("tx_8001");

      // Abort after 5 bits, then a full 0x1234 frame
      pulse_clear(1'b1, 1'b1);
      send_bits(W'($urandom), 0, 5, 1'b0);
      set_ss(1'b0);
      tick(20);
      set_ss(1'b1);
      tick(4);
      send_bits(16'h1234, 0, 15, 1'b0);
      tick(6);
      check_state("abort_15");
      send_bits(16'h1234, 15, 1, 1'b0);
      tick(6);
      check_state("abort_16");
      chk("abort.word", 32'(bus.rx_data_out), 32'h0000_1234);

      // Clear coincident with the 16th rise suppresses the rollover
      pulse_clear(1'b1, 1'b1);
      send_bits(W'($urandom), 0, 16, 1'b1);
      tick(6);
      check_state("prio_clr");
      send_bits(W'($urandom), 0, 16, 1'b0);
      tick(6);
      check_state("prio_next");

      // Reset mid-frame, then a 0xFFFF frame
      pulse_clear(1'b1, 1'b1);
      send_bits(W'($urandom), 0, 9, 1'b0);
      rst = 1'b1;
      tick(1);
      check_all_zero("mid_reset");
      rst = 1'b0;
      model_reset();
      tick(4);
      send_bits(16'hFFFF, 0, 16, 1'b0);
      tick(6);
      check_state("after_reset");
      chk("after_reset.word", 32'(bus.rx_data_out), 32'h0000_FFFF);

      // Randomized frames with random clears, loads and aborted partial frames
      for (int f = 0; f < 16; f++) begin
         pulse_clear(1'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 1) load_tx(W'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            send_bits(W'($urandom), 0, int'($urandom_range(1, 15)), 1'b0);
            set_ss(1'b0);
            tick(10);
            set_ss(1'b1);
            tick(4);
         end
         w = W'($urandom);
         send_bits(w, 0, 16, 1'b0);
         tick(6);
         check_state("random");
      end

      tick(4);
      chk("rx_queue_drained", 32'(exp_rx_q.size()), 32'(0));
      chk("miso_queue_drained", 32'(exp_miso_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
